io_break_arbiter: RTL and testbench
===================================

Name: io_break_arbiter

Overview:
- N-channel successor to the single-device data-break and interrupt wiring at the PDP8e top level.
- Arbitrates data-break (DMA) requests from NDEV peripherals (RK8E, future TC08/DF32, ...) onto the single CPU break path: data_break, to_mem, dmaAddr, data.
- Aggregates per-device interrupt requests through a software-writable mask into one registered irq for the state machine.
- Sits between the device blocks and state_machine/ma, all on the 100 MHz clock.

Parameters:
- NDEV, 4, number of device channels (1..8).
- AW, 15, break address width (EMA + 12-bit address).
- DW, 12, data word width.

Ports:
- clk  in  1  system clock (100 MHz domain).
- reset  in  1  asynchronous active-high reset.
- clear  in  1  synchronous front-panel/CAF clear; same effect as reset except int_mask.
- brk_req  in  NDEV  per-device break request, level, held until brk_done.
- brk_to_mem  in  NDEV  per-device direction: 1 = device→memory write.
- brk_addr  in  NDEV*AW  per-device address, channel i at [i*AW +: AW].
- brk_wdata  in  NDEV*DW  per-device write data, channel i at [i*DW +: DW].
- break_start  in  1  state machine has entered the break cycle (1-clk pulse).
- break_end  in  1  break cycle complete; mem_rdata valid this clk (1-clk pulse).
- mem_rdata  in  DW  memory read data (mem2disk path).
- int_req  in  NDEV  per-device interrupt request, level.
- mask_we  in  1  write int_mask this clk.
- mask_data  in  NDEV  new int_mask value.
- data_break  out  1  break requested to state machine.
- to_mem  out  1  direction of the granted transfer.
- dma_addr  out  AW  granted address.
- dma_wdata  out  DW  granted write data.
- brk_grant  out  NDEV  one-hot grant, held from REQ through DONE.
- brk_done  out  NDEV  one-hot 1-clk completion pulse.
- brk_rdata  out  DW  captured read data, valid with brk_done, held until next DONE.
- irq  out  1  registered OR of int_req & int_mask.
- int_src  out  3  index of the lowest-numbered pending unmasked interrupt; 0 if none.
- int_mask  out  NDEV  current mask.

Behaviour:
- Reset values:
  - FSM = IDLE.
  - data_break, to_mem, brk_grant, brk_done, irq, int_src = 0.
  - dma_addr, dma_wdata, brk_rdata = 0.
  - int_mask = all ones.
  - Round-robin pointer = 0.
- FSM states: IDLE, REQ, BUSY, DONE.
- IDLE:
  - If any brk_req, select the winner and latch grant, to_mem, dma_addr and dma_wdata from that channel.
  - Assert data_break and go to REQ. Latency is 1 clk from request to data_break.
- REQ:
  - data_break held high; outputs are stable.
  - break_start → BUSY.
  - If the winner drops brk_req before break_start, abort: deassert data_break, clear grant, return to IDLE, no brk_done.
- BUSY:
  - data_break deasserted; grant and address held.
  - break_end → DONE, capturing mem_rdata into brk_rdata.
  - brk_req changes are ignored.
- DONE:
  - brk_done[winner] = 1 for exactly one clk, then grant cleared, pointer updated, go to IDLE.
  - A device that is still requesting re-arbitrates on the next IDLE cycle. There is at least 1 idle clk between grants.
- break_start received in IDLE or BUSY, or break_end received outside BUSY: ignored.
- clear, at any state: synchronously returns to IDLE and zeroes grant, done, data_break and irq. int_mask is not changed.
- reset mid-transfer: immediate return to reset values. The device sees its grant drop without brk_done.
- Interrupt path:
  - irq and int_src are registered from int_req & int_mask, 1 clk latency.
  - With mask_we in the same clk, the new mask applies from the next clk's evaluation.
- Unused upper int_src bits are 0 when NDEV < 8.

Optional Feature:
- Macro: ARB_ROUND_ROBIN_EN.
- Defined:
  - Winner = first requesting channel at or above the pointer, with wrap-around.
  - After DONE the pointer becomes winner+1 mod NDEV.
- Undefined:
  - Fixed priority: lowest requesting index wins.
  - The pointer register is omitted.

Test Plan:
- Single request: brk_req=0001, to_mem=1, addr ch0=15'o01234, wdata=12'o7070.
  - Required: data_break 1 clk later, dma_addr=01234, to_mem=1.
  - Drive break_start, then break_end 3 clk later → brk_done=0001 for 1 clk, then data_break stays 0.
- Simultaneous requests: brk_req=1010.
  - Fixed priority: ch1 wins, then ch3.
  - Round-robin with pointer at 2: ch3 first, then ch1.
  - brk_done pulses appear in that order.
- Read capture: ch2 with to_mem=0; mem_rdata=12'o4321 on break_end → brk_rdata=4321 coincident with brk_done=0100.
- Abort: ch0 drops brk_req while in REQ → data_break falls next clk, no brk_done, FSM back in IDLE.
- Interrupts: int_req=0110, mask=1011 → irq=1, int_src=1 after 1 clk. Write mask=1001 → irq=0 the clk after.
- clear and reset during BUSY:
  - clear → grant=0, irq=0, mask retained.
  - Asynchronous reset pulse → all outputs at reset values, int_mask=1111.

Source files
------------

// File: rtl/io_break_arbiter.sv
// Data-break (DMA) arbiter for NDEV devices onto the single CPU break path, plus masked interrupt aggregation.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; otherwise the lowest requesting index wins.
module io_break_arbiter #(
    parameter int NDEV = 4,
    parameter int AW   = 15,
    parameter int DW   = 12
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               clear,
    input  logic [NDEV-1:0]    brk_req,
    input  logic [NDEV-1:0]    brk_to_mem,
    input  logic [NDEV*AW-1:0] brk_addr,
    input  logic [NDEV*DW-1:0] brk_wdata,
    input  logic               break_start,
    input  logic               break_end,
    input  logic [DW-1:0]      mem_rdata,
    input  logic [NDEV-1:0]    int_req,
    input  logic               mask_we,
    input  logic [NDEV-1:0]    mask_data,
    output logic               data_break,
    output logic               to_mem,
    output logic [AW-1:0]      dma_addr,
    output logic [DW-1:0]      dma_wdata,
    output logic [NDEV-1:0]    brk_grant,
    output logic [NDEV-1:0]    brk_done,
    output logic [DW-1:0]      brk_rdata,
    output logic               irq,
    output logic [2:0]         int_src,
    output logic [NDEV-1:0]    int_mask,
    output logic [1:0]         fsm_state
);

    localparam int PW = (NDEV > 1) ? $clog2(NDEV) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        BUSY = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t          state, state_next;
    logic            sel_any;
    logic [PW-1:0]   sel_idx;
    logic [NDEV-1:0] sel_onehot;
    logic            abort;
    logic [NDEV-1:0] pend;
    logic [2:0]      src_next;

    assign fsm_state = state;

`ifdef ARB_ROUND_ROBIN_EN
    logic [PW-1:0] ptr;
    logic [PW-1:0] win_idx;

    // Scan starting at the pointer, wrapping past the top channel.
    always_comb begin
        int c;
        sel_any = 1'b0;
        sel_idx = '0;
        c       = 0;
        for (int k = 0; k < NDEV; k++) begin
            c = int'(ptr) + k;
            if (c >= NDEV) c = c - NDEV;
            if (!sel_any && brk_req[c]) begin
                sel_any = 1'b1;
                sel_idx = PW'(c);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr     <= '0;
            win_idx <= '0;
        end else if (clear) begin
            ptr     <= '0;
            win_idx <= '0;
        end else begin
            if (state == IDLE && sel_any) win_idx <= sel_idx;
            if (state == DONE) ptr <= (win_idx == PW'(NDEV - 1)) ? '0 : win_idx + 1'b1;
        end
    end
`else
    always_comb begin
        sel_any = |brk_req;
        sel_idx = '0;
        for (int k = NDEV - 1; k >= 0; k--) begin
            if (brk_req[k]) sel_idx = PW'(k);
        end
    end
`endif

    assign sel_onehot = NDEV'(1) << sel_idx;
    assign abort      = ~|(brk_req & brk_grant);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // break_start wins over a same-cycle request drop: the memory cycle is already committed.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (sel_any) state_next = REQ;
            REQ: begin
                if (break_start) state_next = BUSY;
                else if (abort)  state_next = IDLE;
            end
            BUSY: if (break_end) state_next = DONE;
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (clear) state_next = IDLE;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_break <= 1'b0;
            to_mem     <= 1'b0;
            dma_addr   <= '0;
            dma_wdata  <= '0;
            brk_grant  <= '0;
            brk_done   <= '0;
            brk_rdata  <= '0;
        end else if (clear) begin
            data_break <= 1'b0;
            to_mem     <= 1'b0;
            dma_addr   <= '0;
            dma_wdata  <= '0;
            brk_grant  <= '0;
            brk_done   <= '0;
            brk_rdata  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (sel_any) begin
                        brk_grant  <= sel_onehot;
                        to_mem     <= brk_to_mem[sel_idx];
                        dma_addr   <= brk_addr[int'(sel_idx)*AW +: AW];
                        dma_wdata  <= brk_wdata[int'(sel_idx)*DW +: DW];
                        data_break <= 1'b1;
                    end
                end
                REQ: begin
                    if (break_start) begin
                        data_break <= 1'b0;
                    end else if (abort) begin
                        data_break <= 1'b0;
                        brk_grant  <= '0;
                    end
                end
                BUSY: begin
                    if (break_end) begin
                        brk_done  <= brk_grant;
                        brk_rdata <= mem_rdata;
                    end
                end
                DONE: begin
                    brk_done  <= '0;
                    brk_grant <= '0;
                end
                default: ;
            endcase
        end
    end

    assign pend = int_req & int_mask;

    always_comb begin
        src_next = 3'd0;
        for (int k = NDEV - 1; k >= 0; k--) begin
            if (pend[k]) src_next = 3'(k);
        end
    end

    // The mask written this clock only affects the following evaluation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            irq      <= 1'b0;
            int_src  <= 3'd0;
            int_mask <= '1;
        end else if (clear) begin
            irq      <= 1'b0;
            int_src  <= 3'd0;
        end else begin
            irq     <= |pend;
            int_src <= src_next;
            if (mask_we) int_mask <= mask_data;
        end
    end

endmodule

// File: tb/tb_io_break_arbiter.sv
// Self-checking bench for io_break_arbiter: the bench plays the CPU break-cycle side and checks
// each completion against a queue of expected {brk_done, brk_rdata} values.
module tb_io_break_arbiter;

    localparam int NDEV = 4;
    localparam int AW   = 15;
    localparam int DW   = 12;
    localparam int W    = NDEV + DW;

    // Handshake: a device holds brk_req until its brk_done pulse; the bench drops it on seeing brk_done.
    logic               clk, reset, clear;
    logic [NDEV-1:0]    brk_req, brk_to_mem;
    logic [NDEV*AW-1:0] brk_addr;
    logic [NDEV*DW-1:0] brk_wdata;
    logic               break_start, break_end;
    logic [DW-1:0]      mem_rdata;
    logic [NDEV-1:0]    int_req, mask_data;
    logic               mask_we;
    logic               data_break, to_mem, irq;
    logic [AW-1:0]      dma_addr;
    logic [DW-1:0]      dma_wdata, brk_rdata;
    logic [NDEV-1:0]    brk_grant, brk_done, int_mask;
    logic [2:0]         int_src;
    logic [1:0]         fsm_state;

    logic [AW-1:0] dev_addr [NDEV];
    logic [DW-1:0] dev_wdata[NDEV];

    int n_cmp = 0;
    int n_bad = 0;
    logic [W-1:0] exp_q[$];

    for (genvar g = 0; g < NDEV; g++) begin : g_pack
        assign brk_addr[g*AW +: AW]  = dev_addr[g];
        assign brk_wdata[g*DW +: DW] = dev_wdata[g];
    end

    io_break_arbiter #(.NDEV(NDEV), .AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .clear(clear),
        .brk_req(brk_req), .brk_to_mem(brk_to_mem), .brk_addr(brk_addr), .brk_wdata(brk_wdata),
        .break_start(break_start), .break_end(break_end), .mem_rdata(mem_rdata),
        .int_req(int_req), .mask_we(mask_we), .mask_data(mask_data),
        .data_break(data_break), .to_mem(to_mem), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .brk_grant(brk_grant), .brk_done(brk_done), .brk_rdata(brk_rdata),
        .irq(irq), .int_src(int_src), .int_mask(int_mask), .fsm_state(fsm_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver: wait for data_break, run one break cycle, check the completion against exp_q.
    task automatic serve(input int gap, output int lat);
        logic [W-1:0] exp;
        int ch;
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!data_break && n < 20);
        lat = n;
        n_cmp++;
        if (data_break !== 1'b1) begin
            n_bad++;
            $display("FAIL data_break_wait: got %b want 1 within 20 clk", data_break);
            return;
        end
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $display("FAIL queue_empty: grant %b with no expected transfer", brk_grant);
            return;
        end
        exp = exp_q[0];
        ch = 0;
        for (int k = 0; k < NDEV; k++) if (exp[DW+k]) ch = k;
        n_cmp++;
        if (brk_grant !== exp[W-1:DW]) begin
            n_bad++;
            $display("FAIL grant: got %b want %b", brk_grant, exp[W-1:DW]);
        end
        n_cmp++;
        if ({to_mem, dma_addr, dma_wdata} !== {brk_to_mem[ch], dev_addr[ch], dev_wdata[ch]}) begin
            n_bad++;
            $display("FAIL xfer_fields: got to_mem=%b addr=%o wdata=%o want %b %o %o",
                     to_mem, dma_addr, dma_wdata, brk_to_mem[ch], dev_addr[ch], dev_wdata[ch]);
        end
        break_start = 1'b1;
        @(negedge clk);
        break_start = 1'b0;
        n_cmp++;
        if (data_break !== 1'b0 || brk_grant !== exp[W-1:DW] || fsm_state !== 2'd2) begin
            n_bad++;
            $display("FAIL busy: got data_break=%b grant=%b state=%0d want 0 %b 2",
                     data_break, brk_grant, fsm_state, exp[W-1:DW]);
        end
        repeat (gap - 1) @(negedge clk);
        break_end = 1'b1;
        mem_rdata = exp[DW-1:0];
        @(negedge clk);
        break_end = 1'b0;
        mem_rdata = DW'($urandom_range(0, 4095));
        exp = exp_q.pop_front();
        n_cmp++;
        if ({brk_done, brk_rdata} !== exp) begin
            n_bad++;
            $display("FAIL done: got done=%b rdata=%o want %b %o", brk_done, brk_rdata, exp[W-1:DW], exp[DW-1:0]);
        end
        brk_req[ch] = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (brk_done !== '0 || brk_grant !== '0 || data_break !== 1'b0) begin
            n_bad++;
            $display("FAIL after_done: got done=%b grant=%b data_break=%b want 0 0 0", brk_done, brk_grant, data_break);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; clear = 1'b0; brk_req = '0; break_start = 1'b0; break_end = 1'b0;
        mem_rdata = '0; int_req = '0; mask_we = 1'b0; mask_data = '0;
        brk_to_mem = 4'b1011;
        dev_addr[0] = 15'o01234; dev_wdata[0] = 12'o7070;
        dev_addr[1] = 15'o10100; dev_wdata[1] = 12'o1111;
        dev_addr[2] = 15'o20222; dev_wdata[2] = 12'o0000;
        dev_addr[3] = 15'o77777; dev_wdata[3] = 12'o7777;
        repeat (2) @(negedge clk);
        n_cmp++;
        if ({data_break, to_mem, brk_grant, brk_done, irq, int_src, dma_addr, dma_wdata, brk_rdata, int_mask, fsm_state}
            !== {1'b0, 1'b0, 4'b0, 4'b0, 1'b0, 3'd0, 15'd0, 12'd0, 12'd0, 4'b1111, 2'd0}) begin
            n_bad++;
            $display("FAIL reset_values: got db=%b grant=%b done=%b irq=%b src=%0d addr=%o mask=%b state=%0d",
                     data_break, brk_grant, brk_done, irq, int_src, dma_addr, int_mask, fsm_state);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single();
        int lat;
        brk_req = 4'b0001;
        exp_q.push_back({4'b0001, DW'($urandom_range(0, 4095))});
        serve(3, lat);
        n_cmp++;
        if (lat !== 1) begin
            n_bad++;
            $display("FAIL single_latency: got %0d clk want 1", lat);
        end
        @(negedge clk);
        n_cmp++;
        if (data_break !== 1'b0 || fsm_state !== 2'd0) begin
            n_bad++;
            $display("FAIL single_quiet: got data_break=%b state=%0d want 0 0", data_break, fsm_state);
        end
    endtask

    task automatic test_abort();
        int n;
        logic seen_done;
        brk_req = 4'b0001;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!data_break && n < 20);
        brk_req = 4'b0000;
        seen_done = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (data_break !== 1'b0 || brk_grant !== '0 || fsm_state !== 2'd0) begin
            n_bad++;
            $display("FAIL abort: got data_break=%b grant=%b state=%0d want 0 0 0", data_break, brk_grant, fsm_state);
        end
        repeat (3) begin
            if (brk_done !== '0) seen_done = 1'b1;
            @(negedge clk);
        end
        n_cmp++;
        if (seen_done !== 1'b0) begin
            n_bad++;
            $display("FAIL abort_no_done: got done pulse=%b want 0", seen_done);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        brk_req = 4'b0010;
        exp_q.push_back({4'b0010, DW'($urandom_range(0, 4095))});
        serve(2, lat);
        brk_req = 4'b1010;
`ifdef ARB_ROUND_ROBIN_EN
        exp_q.push_back({4'b1000, DW'($urandom_range(0, 4095))});
        exp_q.push_back({4'b0010, DW'($urandom_range(0, 4095))});
`else
        exp_q.push_back({4'b0010, DW'($urandom_range(0, 4095))});
        exp_q.push_back({4'b1000, DW'($urandom_range(0, 4095))});
`endif
        serve(1, lat);
        serve(4, lat);
    endtask

    task automatic test_read_capture();
        int lat;
        brk_req = 4'b0100;
        exp_q.push_back({4'b0100, 12'o4321});
        serve(3, lat);
    endtask

    task automatic test_stray_pulses();
        break_start = 1'b1;
        @(negedge clk);
        break_start = 1'b0;
        break_end = 1'b1;
        @(negedge clk);
        break_end = 1'b0;
        n_cmp++;
        if (fsm_state !== 2'd0 || brk_done !== '0 || data_break !== 1'b0) begin
            n_bad++;
            $display("FAIL stray_pulses: got state=%0d done=%b data_break=%b want 0 0 0", fsm_state, brk_done, data_break);
        end
    endtask

    task automatic test_interrupts();
        mask_we = 1'b1; mask_data = 4'b1011;
        @(negedge clk);
        mask_we = 1'b0; int_req = 4'b0110;
        @(negedge clk);
        n_cmp++;
        if ({irq, int_src, int_mask} !== {1'b1, 3'd1, 4'b1011}) begin
            n_bad++;
            $display("FAIL irq_pending: got irq=%b src=%0d mask=%b want 1 1 1011", irq, int_src, int_mask);
        end
        mask_we = 1'b1; mask_data = 4'b1001;
        @(negedge clk);
        mask_we = 1'b0;
        n_cmp++;
        if (irq !== 1'b1) begin
            n_bad++;
            $display("FAIL irq_old_mask: got %b want 1", irq);
        end
        @(negedge clk);
        n_cmp++;
        if ({irq, int_src} !== {1'b0, 3'd0}) begin
            n_bad++;
            $display("FAIL irq_masked: got irq=%b src=%0d want 0 0", irq, int_src);
        end
        int_req = 4'b1000;
        @(negedge clk);
        n_cmp++;
        if ({irq, int_src} !== {1'b1, 3'd3}) begin
            n_bad++;
            $display("FAIL irq_top_channel: got irq=%b src=%0d want 1 3", irq, int_src);
        end
    endtask

    task automatic test_clear_reset();
        mask_we = 1'b1; mask_data = 4'b1010; int_req = 4'b0010;
        @(negedge clk);
        mask_we = 1'b0;
        brk_req = 4'b0100;
        @(negedge clk);
        break_start = 1'b1;
        @(negedge clk);
        break_start = 1'b0;
        n_cmp++;
        if ({fsm_state, irq, brk_grant} !== {2'd2, 1'b1, 4'b0100}) begin
            n_bad++;
            $display("FAIL pre_clear: got state=%0d irq=%b grant=%b want 2 1 0100", fsm_state, irq, brk_grant);
        end
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        n_cmp++;
        if ({brk_grant, data_break, irq, int_mask, fsm_state, dma_addr} !== {4'b0, 1'b0, 1'b0, 4'b1010, 2'd0, 15'd0}) begin
            n_bad++;
            $display("FAIL clear: got grant=%b db=%b irq=%b mask=%b state=%0d addr=%o want 0 0 0 1010 0 0",
                     brk_grant, data_break, irq, int_mask, fsm_state, dma_addr);
        end
        @(negedge clk);
        n_cmp++;
        if ({data_break, brk_grant, irq} !== {1'b1, 4'b0100, 1'b1}) begin
            n_bad++;
            $display("FAIL after_clear: got db=%b grant=%b irq=%b want 1 0100 1", data_break, brk_grant, irq);
        end
        break_start = 1'b1;
        @(negedge clk);
        break_start = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_cmp++;
        if ({data_break, to_mem, brk_grant, brk_done, irq, int_src, dma_addr, int_mask, fsm_state}
            !== {1'b0, 1'b0, 4'b0, 4'b0, 1'b0, 3'd0, 15'd0, 4'b1111, 2'd0}) begin
            n_bad++;
            $display("FAIL async_reset: got db=%b grant=%b done=%b irq=%b addr=%o mask=%b state=%0d",
                     data_break, brk_grant, brk_done, irq, dma_addr, int_mask, fsm_state);
        end
        brk_req = '0;
        int_req = '0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_single();
        test_abort();
        test_back_to_back();
        test_read_capture();
        test_stray_pulses();
        test_interrupts();
        test_clear_reset();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL queue_drain: got %0d left want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
